// File: rtl/aes_pkg.sv
// Shared AES types, the FSM encoding and the forward S-box table
// used by the iterative SubBytes stage.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sb_state_e;

  // Forward S-box: GF(2^8) inverse mod 0x11B followed by the affine map (+0x63)
  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox.sv
// Single combinational forward S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t sbox_i,
  output byte_t sbox_o
);

  assign sbox_o = SBOX[sbox_i];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES shared S-boxes substitute a 128-bit state
// over 16/LANES cycles, then hold the result until downstream accepts it.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  state_t    in_state,
  output logic      out_valid,
  input  logic      out_ready,
  output state_t    out_state,
  output logic      busy,
  output sb_state_e dbg_state
);

  localparam int STEPS = 16 / LANES;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready may depend combinationally on out_ready (DONE->RUN back-to-back path).
  sb_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  state_t           src_q, src_d;
  state_t           res_q, res_d;
  byte_t            lane_in  [LANES];
  byte_t            lane_out [LANES];

  // Byte j of the state lives at bits [127-8j -: 8]; lane l handles byte idx*LANES+l.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = src_q[127 - 8 * (int'(idx_q) * LANES + l) -: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .sbox_i (lane_in[g]),
      .sbox_o (lane_out[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    src_d    = src_q;
    res_d    = res_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          src_d   = in_state;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          res_d[127 - 8 * (int'(idx_q) * LANES + l) -: 8] = lane_out[l];
        end
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            src_d   = in_state;
            idx_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_state = res_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: one instance per legal LANES value, directed
// FIPS-197 vectors plus streaming/random traffic scored against a GF(2^8) model.
module tb_sub_bytes_iter;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] EDGE_IN  = 128'h5301_0000_0000_0000_0000_0000_0000_00ff;
  localparam logic [127:0] EDGE_OUT = 128'hed7c_6363_6363_6363_6363_6363_6363_6316;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic         in_valid  [5];
  logic         in_ready  [5];
  logic [127:0] in_state  [5];
  logic         out_valid [5];
  logic         out_ready [5];
  logic [127:0] out_state [5];
  logic         busy      [5];
  sb_state_e    dbg_state [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_iter #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model built from the field arithmetic, not from a table
  logic [7:0] ref_sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] model_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = ref_sbox[s[127 - 8*j -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*(((c + rw) % 4)) + rw) -: 8];
    return r;
  endfunction

  // scoreboard (monitors the instance selected by sel)
  logic [127:0] exp_q [$];
  int sel      = 2;
  bit stream   = 1'b0;
  int last_out = -1;
  int out_cnt  = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", 128'(in_ready[sel]), 128'd0);
      exp_q.delete();
      last_out = -1;
    end else begin
      if (out_valid[sel] && out_ready[sel]) begin
        check("sb_has_exp", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) check("sb_data", out_state[sel], exp_q.pop_front());
        if (stream && last_out >= 0) check("sb_interval", 128'(cyc - last_out), 128'((16 >> sel) + 1));
        last_out = cyc;
        out_cnt++;
      end
      if (in_valid[sel] && in_ready[sel]) exp_q.push_back(model_sub(in_state[sel]));
    end
  end

  // driver tasks
  task automatic send(input int k, input logic [127:0] s, output int t_in);
    bit got = 1'b0;
    in_state[k] = s;
    in_valid[k] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = in_ready[k];
    end
    if (!got) check("send_timeout", 128'(in_ready[k]), 128'd1);
    t_in = cyc;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int t_out, output logic [127:0] s);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = out_valid[k];
    end
    if (!got) check("out_timeout", 128'(out_valid[k]), 128'd1);
    t_out = cyc;
    s = out_state[k];
    @(posedge clk); #1;
  endtask

  task automatic accept(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    check(tag, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_in, t_out;
    logic [127:0] s;

    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      if (i != 0) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(i));
      end
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      ref_sbox[i] = b;
    end
    for (int k = 0; k < 5; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_state[k] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    in_valid[2] = 1'b1; out_ready[2] = 1'b1;
    @(negedge clk);
    check("rst_state", 128'(dbg_state[2]), 128'(IDLE));
    check("rst_out_valid", 128'(out_valid[2]), 128'd0);
    check("rst_out_state", out_state[2], 128'd0);
    check("rst_busy", 128'(busy[2]), 128'd0);
    check("rst_in_ready_l16", 128'(in_ready[4]), 128'd0);
    @(posedge clk); #1;
    in_valid[2] = 1'b0; out_ready[2] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 128'(in_ready[2]), 128'd1);
    @(posedge clk); #1;

    // single-byte table check on LANES=16
    sel = 4;
    send(4, 128'd0, t_in);
    wait_out(4, t_out, s);
    check("l16_zero", s, ALL_63);
    check("l16_latency", 128'(t_out - t_in), 128'd2);
    accept(4);
    send(4, EDGE_IN, t_in);
    wait_out(4, t_out, s);
    check("l16_edge", s, EDGE_OUT);
    accept(4);

    // FIPS-197 round 1 on LANES=4
    sel = 2;
    send(2, FIPS_IN, t_in);
    wait_out(2, t_out, s);
    check("fips_sub", s, FIPS_SB);
    check("fips_latency", 128'(t_out - t_in), 128'd5);
    check("fips_shift", shift_rows(s), FIPS_SR);
    check("fips_busy", 128'(busy[2]), 128'd1);
    accept(2);
    check("fips_idle", 128'(dbg_state[2]), 128'(IDLE));

    // backpressure then same-cycle output/input transfer
    send(2, FIPS_IN, t_in);
    wait_out(2, t_out, s);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", out_state[2], FIPS_SB);
      check("bp_in_ready", 128'(in_ready[2]), 128'd0);
      check("bp_out_valid", 128'(out_valid[2]), 128'd1);
      @(posedge clk); #1;
    end
    in_state[2] = 128'd0; in_valid[2] = 1'b1; out_ready[2] = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", 128'(in_ready[2]), 128'd1);
    t_in = cyc;
    @(posedge clk); #1;
    in_valid[2] = 1'b0; out_ready[2] = 1'b0;
    check("b2b_state", 128'(dbg_state[2]), 128'(RUN));
    check("b2b_out_valid", 128'(out_valid[2]), 128'd0);
    wait_out(2, t_out, s);
    check("b2b_data", s, ALL_63);
    check("b2b_latency", 128'(t_out - t_in), 128'd5);
    accept(2);

    // reset in RUN at idx=2
    send(2, 128'h0123456789abcdeffedcba9876543210, t_in);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_run", 128'(dbg_state[2]), 128'(RUN));
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_state", 128'(dbg_state[2]), 128'(IDLE));
    check("abort_out_valid", 128'(out_valid[2]), 128'd0);
    check("abort_out_state", out_state[2], 128'd0);
    rst = 1'b0;
    send(2, FIPS_IN, t_in);
    wait_out(2, t_out, s);
    check("post_abort", s, FIPS_SB);
    accept(2);
    drain("directed_drain");

    // streaming with everything tied high, every LANES value
    for (int k = 0; k < 5; k++) begin
      sel = k; stream = 1'b1; last_out = -1; out_cnt = 0;
      out_ready[k] = 1'b1;
      for (int n = 0; n < 100; n++) send(k, {$urandom, $urandom, $urandom, $urandom}, t_in);
      drain("stream_drain");
      check("stream_count", 128'(out_cnt), 128'd100);
      stream = 1'b0; out_ready[k] = 1'b0;
    end

    // random handshake toggling with occasional resets
    sel = 2;
    for (int i = 0; i < 10000; i++) begin
      rst          = ($urandom_range(0, 499) == 0);
      in_valid[2]  = $urandom_range(0, 1);
      out_ready[2] = $urandom_range(0, 1);
      in_state[2]  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid[2] = 1'b0; out_ready[2] = 1'b1;
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative AES-128 SubBytes stage that sits directly upstream of the row-shift stage in the round datapath. It accepts one 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through shared S-box instances. It then presents the substituted state, held stable, until the downstream stage accepts it. The multi-cycle design trades latency for S-box area.

## Interface
- LANES, default 4: number of S-box instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is a elaboration error.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream holds a valid state on in_state.
- in_ready  output  1  block can accept in_state this cycle.
- in_state  input  128  state to substitute. Bits [127:120] are byte 0 (row 0, column 0). Bits [127:96] are column 0, bits [31:0] are column 3. Within a column the MSB byte is row 0.
- out_valid  output  1  out_state holds a complete substituted state.
- out_ready  input  1  downstream accepts out_state this cycle.
- out_state  output  128  substituted state; same byte layout as in_state.
- busy  output  1  high in RUN or DONE.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid and in_ready are both high.
  - An output transfer occurs when out_valid and out_ready are both high.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On an input transfer, capture in_state into src_q, set idx=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, substitute bytes idx*LANES .. idx*LANES+LANES-1 of src_q, with byte 0 at the MSB. Write the results into the same byte positions of res_q, then increment idx. When idx = 16/LANES-1, go to DONE after that write.
  - DONE: out_valid=1, out_state=res_q. On an output transfer, go to IDLE. If in_valid is also high in that cycle, capture the new state and go straight to RUN.
- in_ready = (state==IDLE) or (state==DONE and out_ready). It is 0 whenever rst is high.
- idx is a counter of width clog2(16/LANES), minimum 1 bit. It wraps to 0 on entry to RUN and never exceeds 16/LANES-1.
- src_q and res_q change only on an input transfer or a RUN write. out_state is stable while out_valid=1 and out_ready=0.
- Any out_ready or in_valid activity in RUN is ignored; no input transfer is possible in RUN.
- S-box mapping: multiplicative inverse in GF(2^8) with polynomial 0x11B, followed by the FIPS-197 affine transform (constant 0x63). It is implemented as a 256-entry constant table.

## Timing
- Reset state: FSM in IDLE, idx=0, src_q=0, res_q=0, out_valid=0, out_state=0, busy=0, in_ready=0 during reset.
- The first input transfer can occur on the first cycle after rst deasserts.
- Latency: input transfer in cycle T gives out_valid=1 in cycle T+16/LANES+1. With LANES=4, out_valid rises at T+5.
- Throughput: one state per 16/LANES+1 cycles when out_ready is tied high. This is achieved through the DONE→RUN back-to-back path.
- Reset mid-operation (RUN or DONE): the FSM returns to IDLE on the next edge. The partial result is discarded, out_valid drops, and no output transfer occurs for the aborted state.
- out_valid, out_state and busy are registered or derived only from FSM state. in_ready is the only output with a combinational path from an input (out_ready).

## Structure
- Package aes_pkg contains:
  - typedef byte_t (logic [7:0]);
  - typedef state_t (logic [127:0]);
  - constant SBOX, a 256-entry byte_t array;
  - the FSM enum (IDLE, RUN, DONE).
- Sub-module aes_sbox: combinational byte_t in → byte_t out via aes_pkg::SBOX. sub_bytes_iter instantiates it LANES times in a generate loop.

## Test plan
- Single-byte table check (LANES=16): in_state=0x00..00 → out_state=0x63 repeated 16 times. in_state with byte 0 = 0x53, byte 1 = 0x01, byte 15 = 0xFF, all other bytes 0x00 → out_state bytes 0x63 everywhere except byte 0 = 0xED, byte 1 = 0x7C, byte 15 = 0x16.
- FIPS-197 Appendix B round 1 (LANES=4):
  - in_state = 0x193de3bea0f4e22b9ac68d2ae9f84808 → out_state = 0xd42711aee0bf98f1b8b45de51e415230.
  - out_valid is first high exactly 5 cycles after the input transfer.
  - Chaining into the row-shift stage gives 0xd4bf5d30e0b452aeb84111f11e2798e5.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_state stable, in_ready=0. Then pulse out_ready with in_valid high → output transfer and new input capture occur in the same cycle, and the next out_valid appears 5 cycles later.
- Streaming, all legal LANES values: 100 random states with in_valid/out_ready tied high → outputs match the reference model, in order, one every 16/LANES+1 cycles.
- Reset mid-RUN: assert rst at idx=2 → next cycle FSM is IDLE, out_valid=0, out_state=0. The next state is processed correctly with no residue from the aborted one.
- Random in_valid/out_ready toggling for 10k cycles → no lost, duplicated or reordered states, and no transfer while rst is high.
